// File: rtl/trap_capture_pkg.sv
// Shared mapper definitions for the trap capture FIFO.
// Includes the trap record layout, the stream byte-sequencer states and the value returned for an empty read.
package trap_capture_pkg;

    localparam int DIR_W  = 1;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [7:0] EMPTY_READ = 8'hFF;

    typedef enum logic [1:0] {
        S_LO  = 2'd0,
        S_HI  = 2'd1,
        S_DAT = 2'd2
    } stream_state_e;

    typedef struct packed {
        logic [DIR_W-1:0]  dir;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } trap_rec_t;

    // IN cycles carry no meaningful CPU data, so the stored data byte is forced to zero.
    function automatic trap_rec_t make_rec(logic dir, logic [ADDR_W-1:0] addr,
                                           logic [DATA_W-1:0] data);
        trap_rec_t r;
        r.dir  = dir;
        r.addr = addr;
        r.data = dir ? data : '0;
        return r;
    endfunction

endpackage

// File: rtl/trap_capture_edge_detect.sv
// Rising-edge detector built on a registered copy of the input.
// The register resets to 1, so an input that is already high when reset releases produces no event.
module edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic pulse
);

    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= 1'b1;
        else          prev_q <= sig;
    end

    assign pulse = sig & ~prev_q;

endmodule

// File: rtl/trap_capture.sv
// Buffers mapper I/O violation records for the hypervisor.
// Records are read back through a status port and a three-byte stream port.
//   state | meaning
//   S_LO  | stream port presents head addr[7:0]
//   S_HI  | stream port presents head addr[15:8]
//   S_DAT | stream port presents head data; next stream read pops
module trap_capture
    import trap_capture_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trap_strobe,
    input  logic [15:0] trap_addr,
    input  logic        trap_dir,
    input  logic [7:0]  trap_data,
    input  logic        rd_req,
    input  logic        rd_sel,
    input  logic        clr,
    output logic [7:0]  data_out,
    output logic        pending,
    output logic        overflow,
    output logic [3:0]  count
);

    localparam int PW = $clog2(DEPTH);

    logic          trap_ev;
    logic          rd_ev;
    logic          stream_ev;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic [PW:0]   head_q;
    logic [PW:0]   tail_q;
    logic [PW:0]   occ;
    logic          overflow_q;
    trap_rec_t     head_rec;
    trap_rec_t     mem [DEPTH];
    stream_state_e state_q;
    stream_state_e state_d;

    edge_detect u_trap_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (trap_strobe),
        .pulse   (trap_ev)
    );

    edge_detect u_rd_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (rd_req),
        .pulse   (rd_ev)
    );

    assign occ       = tail_q - head_q;
    assign empty     = (occ == '0);
    assign full      = (occ == (PW+1)'(DEPTH));
    assign stream_ev = rd_ev & rd_sel;
    assign pop       = stream_ev & ~empty & (state_q == S_DAT);
    // A full FIFO still accepts a push when the head slot is being freed in the same clock.
    assign push_ok   = trap_ev & (~full | pop);
    assign head_rec  = mem[head_q[PW-1:0]];

    assign count    = 4'(occ);
    assign pending  = ~empty;
    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            head_q     <= '0;
            tail_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) tail_q <= tail_q + 1'b1;
            if (pop)     head_q <= head_q + 1'b1;
            if (trap_ev && full && !pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[tail_q[PW-1:0]] <= make_rec(trap_dir, trap_addr, trap_data);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_LO;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_LO;
        end else if (stream_ev && !empty) begin
            case (state_q)
                S_LO:    state_d = S_HI;
                S_HI:    state_d = S_DAT;
                S_DAT:   state_d = S_LO;
                default: state_d = S_LO;
            endcase
        end
    end

    always_comb begin
        data_out = EMPTY_READ;
        if (!rd_sel) begin
            data_out = {overflow_q, ~empty, (empty ? 1'b0 : head_rec.dir[0]), state_q, count[2:0]};
        end else if (!empty) begin
            case (state_q)
                S_LO:    data_out = head_rec.addr[7:0];
                S_HI:    data_out = head_rec.addr[15:8];
                S_DAT:   data_out = head_rec.data;
                default: data_out = EMPTY_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_capture.sv
// Directed self-checking bench for trap_capture (DEPTH = 4).
module tb_trap_capture;

    logic        clk;
    logic        reset_n;
    logic        trap_strobe;
    logic [15:0] trap_addr;
    logic        trap_dir;
    logic [7:0]  trap_data;
    logic        rd_req;
    logic        rd_sel;
    logic        clr;
    logic [7:0]  data_out;
    logic        pending;
    logic        overflow;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    trap_capture #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .trap_strobe (trap_strobe),
        .trap_addr   (trap_addr),
        .trap_dir    (trap_dir),
        .trap_data   (trap_data),
        .rd_req      (rd_req),
        .rd_sel      (rd_sel),
        .clr         (clr),
        .data_out    (data_out),
        .pending     (pending),
        .overflow    (overflow),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_status(string tag, logic [7:0] exp);
        rd_sel = 1'b0;
        #1;
        check(tag, data_out, exp);
    endtask

    task automatic check_count(string tag, logic [3:0] exp_cnt, logic exp_pend, logic exp_ovf);
        check({tag, "_count"}, {4'b0, count}, {4'b0, exp_cnt});
        check({tag, "_pending"}, {7'b0, pending}, {7'b0, exp_pend});
        check({tag, "_overflow"}, {7'b0, overflow}, {7'b0, exp_ovf});
    endtask

    task automatic stream_read(string tag, logic [7:0] exp);
        rd_sel = 1'b1;
        rd_req = 1'b1;
        #1;
        check(tag, data_out, exp);
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic trap(logic dir, logic [15:0] addr, logic [7:0] data, int hold);
        trap_dir    = dir;
        trap_addr   = addr;
        trap_data   = data;
        trap_strobe = 1'b1;
        repeat (hold) tick();
        trap_strobe = 1'b0;
        tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        trap_strobe = 1'b0;
        trap_addr   = '0;
        trap_dir    = 1'b0;
        trap_data   = '0;
        rd_req      = 1'b0;
        rd_sel      = 1'b1;
        clr         = 1'b0;

        // Reset values
        #12;
        check("rst_stream", data_out, 8'hFF);
        check_status("rst_status", 8'h00);
        check_count("rst", 4'd0, 1'b0, 1'b0);

        // Strobe already high when reset releases: no push
        trap_strobe = 1'b1;
        trap_addr   = 16'hDEAD;
        trap_dir    = 1'b1;
        #1 reset_n  = 1'b1;
        tick(); tick(); tick();
        trap_strobe = 1'b0;
        tick();
        check_count("rel_strobe", 4'd0, 1'b0, 1'b0);

        // OUT trap held 3 clocks pushes once
        trap(1'b1, 16'h12A8, 8'h5C, 3);
        check_count("out1", 4'd1, 1'b1, 1'b0);
        check_status("out1_status", 8'h61);
        stream_read("out1_lo", 8'hA8);
        stream_read("out1_hi", 8'h12);
        stream_read("out1_dat", 8'h5C);
        check_count("out1_after", 4'd0, 1'b0, 1'b0);

        // IN trap stores zero data
        trap(1'b0, 16'h00BF, 8'h77, 1);
        check_status("in1_status", 8'h41);
        stream_read("in1_lo", 8'hBF);
        stream_read("in1_hi", 8'h00);
        stream_read("in1_dat", 8'h00);

        // Five traps into DEPTH=4 -> overflow, fifth dropped
        for (int i = 1; i <= 5; i++)
            trap(1'b1, 16'h1000 + 16'(i), 8'(i * 16'h11), 1);
        check_count("ovf", 4'd4, 1'b1, 1'b1);
        check_status("ovf_status", 8'hE4);
        for (int i = 1; i <= 4; i++) begin
            stream_read("ovf_lo", 8'(i));
            stream_read("ovf_hi", 8'h10);
            stream_read("ovf_dat", 8'(i * 16'h11));
        end
        stream_read("ovf_fifth_absent", 8'hFF);
        check_count("ovf_drained", 4'd0, 1'b0, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_count("clr1", 4'd0, 1'b0, 1'b0);

        // clr mid-sequence flushes records and returns FSM to S_LO
        trap(1'b1, 16'h0A0B, 8'h0C, 1);
        trap(1'b1, 16'h0D0E, 8'h0F, 1);
        stream_read("clr2_lo", 8'h0B);
        check_status("clr2_pre", 8'h6A);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_status("clr2_post", 8'h00);

        // Full FIFO, trap edge coincident with the popping stream read
        for (int i = 1; i <= 4; i++)
            trap(1'b1, 16'h2000 + 16'(i), 8'hA0 + 8'(i), 1);
        stream_read("full_lo", 8'h01);
        stream_read("full_hi", 8'h20);
        rd_sel      = 1'b1;
        rd_req      = 1'b1;
        trap_dir    = 1'b1;
        trap_addr   = 16'h2005;
        trap_data   = 8'hA5;
        trap_strobe = 1'b1;
        #1;
        check("full_dat", data_out, 8'hA1);
        tick();
        rd_req      = 1'b0;
        trap_strobe = 1'b0;
        tick();
        check_count("full_coinc", 4'd4, 1'b1, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            stream_read("coinc_lo", 8'(i));
            stream_read("coinc_hi", 8'h20);
            stream_read("coinc_dat", 8'hA0 + 8'(i));
        end
        check_count("coinc_drained", 4'd0, 1'b0, 1'b0);

        // Empty stream read leaves FSM in S_LO
        stream_read("empty_read", 8'hFF);
        check_status("empty_status", 8'h00);

        // Reset pulse mid-sequence discards partial read
        trap(1'b1, 16'h3344, 8'h66, 1);
        stream_read("rst_mid_lo", 8'h44);
        stream_read("rst_mid_hi", 8'h33);
        check_status("rst_mid_pre", 8'h71);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        check_status("rst_mid_post", 8'h00);
        check_count("rst_mid", 4'd0, 1'b0, 1'b0);
        rd_sel = 1'b1;
        #1;
        check("rst_mid_stream", data_out, 8'hFF);
        tick();

        // rd_req held 5 clocks advances exactly once; status reads have no side effects
        trap(1'b1, 16'h5678, 8'h9A, 1);
        rd_sel = 1'b1;
        rd_req = 1'b1;
        repeat (5) tick();
        rd_req = 1'b0;
        tick();
        check_status("hold_status", 8'h69);
        rd_req = 1'b1;
        tick(); tick();
        rd_req = 1'b0;
        tick();
        check_status("status_no_side", 8'h69);
        rd_sel = 1'b1;
        #1;
        check("hold_stream", data_out, 8'h56);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_capture.md
TRAP_CAPTURE -- requirements
Module: trap_capture

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of trap records buffered; power of two, 2..8.
REQ-002 clk  in  1  system clock (Z80 CLK); all state SHALL change on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 trap_strobe  in  1  high while a mapper I/O violation cycle is active; synchronous to clk.
REQ-005 trap_addr  in  16  real Z80 port address of the violating cycle, valid while trap_strobe is high.
REQ-006 trap_dir  in  1  1 = OUT instruction, 0 = IN instruction, valid with trap_strobe.
REQ-007 trap_data  in  8  CPU data bus, valid with trap_strobe; meaningful only for OUT.
REQ-008 rd_req  in  1  high while the hypervisor reads a capture port.
REQ-009 rd_sel  in  1  0 = status port, 1 = stream port; valid with rd_req.
REQ-010 clr  in  1  high for one or more clocks on a hypervisor write to the control port; flush request.
REQ-011 data_out  out  8  read data for the selected port.
REQ-012 pending  out  1  high while at least one record is buffered; feeds NMI request logic.
REQ-013 overflow  out  1  sticky: a trap was dropped because the buffer was full.
REQ-014 count  out  4  number of buffered records, 0..DEPTH.

Function
REQ-015 Record = {dir[1], addr[16], data[8]}; the buffer SHALL be a FIFO of DEPTH records with head/tail pointers that wrap modulo DEPTH.
REQ-016 Push SHALL occur on the first clock where trap_strobe is high and was low on the previous clock (rising-edge detect); a strobe held high SHALL push exactly once.
REQ-017 For IN traps the stored data field SHALL be 0x00.
REQ-018 Read events SHALL be edge-detected on rd_req identically; one hypervisor read = one event regardless of its clock length.
REQ-019 The stream port SHALL use a byte-sequencer FSM with states S_LO, S_HI, S_DAT; reset state S_LO.
REQ-020 In S_LO data_out = head addr[7:0]; S_HI = head addr[15:8]; S_DAT = head data.
REQ-021 A stream read event SHALL advance S_LO->S_HI->S_DAT; in S_DAT it SHALL pop the head and return to S_LO.
REQ-022 Stream read with FIFO empty SHALL return 0xFF and leave FSM and pointers unchanged.
REQ-023 Status port data_out = {overflow, pending, head dir, fsm[1:0] (S_LO=0, S_HI=1, S_DAT=2), count[2:0]}; head dir reads 0 when empty; status reads SHALL have no side effects.
REQ-024 data_out SHALL be combinational from rd_sel and registered state (zero added latency); a push in the same clock becomes visible the next clock.
REQ-025 Push when full with no same-cycle pop SHALL drop the record and set overflow; pointers and count unchanged.
REQ-026 Simultaneous push and pop SHALL both take effect; when full this SHALL NOT set overflow; count unchanged.
REQ-027 Push into empty FIFO SHALL assert pending on the next clock; the final pop SHALL deassert it on the next clock.
REQ-028 clr SHALL empty the FIFO, clear overflow and return the FSM to S_LO; any push or pop in the same clock SHALL be discarded.
REQ-029 count SHALL equal tail-minus-head occupancy, using one extra pointer bit to distinguish full from empty.

Reset
REQ-030 reset_n low SHALL asynchronously set count=0, pending=0, overflow=0, FSM=S_LO, pointers=0 and both edge-detect registers=1 so an input already high at release does not produce an event.
REQ-031 Buffer storage need not be reset; data_out SHALL still read 0xFF on stream and 0x00 on status after reset.
REQ-032 Reset asserted mid-sequence (FSM in S_HI or S_DAT) SHALL discard the partial read with no pop.

Structure
REQ-033 FSM state encodings, record field widths and the empty-read value 0xFF SHALL live in the shared mapper package.
REQ-034 One sub-module, edge_detect (registered rising-edge pulse, reset value 1), SHALL be instantiated twice (trap_strobe, rd_req).

Verification
REQ-035 Reset, one OUT trap addr=0x12A8 data=0x5C held 3 clocks -> count=1, pending=1; stream reads return 0xA8, 0x12, 0x5C; then count=0, pending=0.
REQ-036 IN trap addr=0x00BF -> status = 0b01000000 | count=1 with dir bit 0; stream returns 0xBF, 0x00, 0x00.
REQ-037 DEPTH=4, five traps without reads -> count=4, overflow=1, records 1..4 read in order, fifth absent; clr -> overflow=0, count=0.
REQ-038 FIFO full, trap edge coincident with third stream read -> overflow stays 0, count stays 4, new record is last out.
REQ-039 Stream read on empty FIFO -> 0xFF, FSM stays S_LO; reset_n pulsed after two stream reads -> FSM=S_LO, count=0.
REQ-040 trap_strobe high while reset_n deasserts -> no push; rd_req held 5 clocks -> exactly one FSM advance.
